acc_job_sched: RTL

- Round-robin scheduler that shares one 8-bit accumulator datapath (acc) between N_REQ requesters.
- Each granted requester runs one accumulate job: clear the accumulator, stream len+1 operands into it, then receive the 8-bit sum and a sticky overflow flag.
- Sits between client blocks and the acc instance and drives all of acc's inputs.
- acc adds on every clock edge, so this block forces accin=0 and cin=0 whenever no operand is being accepted.

---
 rtl/acc_job_sched_pkg.sv | 16 +
 rtl/acc_rr_arb.sv | 35 +++
 rtl/acc_job_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/acc_job_sched_pkg.sv
// rtl/acc_job_sched_pkg.sv - shared FSM encoding and widths for acc_job_sched
package acc_job_sched_pkg;

  localparam int N_REQ_DEF = 2;
  localparam int LEN_W_DEF = 4;
  localparam int ACC_W     = 8;
  localparam int IDX_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLR,
    ST_RUN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/acc_rr_arb.sv
// rtl/acc_rr_arb.sv - combinational round-robin pick of the first request at or after ptr
module acc_rr_arb
  import acc_job_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IDX_W-1:0] pick_idx
);

  int pos;

  // Walk offsets from ptr; the first hit wins, so lower offsets have priority.
  always_comb begin
    any      = 1'b0;
    pick_oh  = '0;
    pick_idx = '0;
    pos      = 0;
    for (int off = 0; off < N_REQ; off++) begin
      pos = int'(ptr) + off;
      if (pos >= N_REQ) pos = pos - N_REQ;
      for (int k = 0; k < N_REQ; k++) begin
        if (!any && k == pos && req[k]) begin
          any        = 1'b1;
          pick_oh[k] = 1'b1;
          pick_idx   = IDX_W'(k);
        end
      end
    end
  end

endmodule

// File: rtl/acc_job_sched.sv
// rtl/acc_job_sched.sv - round-robin job scheduler sharing one 8-bit accumulator
module acc_job_sched
  import acc_job_sched_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic                   clk,
  input  logic                   clear_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*LEN_W-1:0] len,
  input  logic [N_REQ-1:0]       op_valid,
  input  logic [N_REQ*ACC_W-1:0] op_data,
  output logic [N_REQ-1:0]       op_ready,
  output logic [N_REQ-1:0]       gnt,
  output logic                   res_valid,
  output logic [IDX_W-1:0]       res_id,
  output logic [ACC_W-1:0]       res_data,
  output logic                   res_ovf,
  output logic [ACC_W-1:0]       acc_accin,
  output logic                   acc_cin,
  output logic                   acc_clear,
  input  logic [ACC_W-1:0]       acc_accout,
  input  logic                   acc_cout
);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gid_q, gid_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             res_valid_q, res_valid_d;

  logic             arb_any;
  logic [N_REQ-1:0] arb_oh;
  logic [IDX_W-1:0] arb_idx;
  logic [LEN_W-1:0] arb_len;
  logic [ACC_W-1:0] g_data;
  logic             accept;

  acc_rr_arb #(.N_REQ(N_REQ)) u_arb (
    .req      (req),
    .ptr      (ptr_q),
    .any      (arb_any),
    .pick_oh  (arb_oh),
    .pick_idx (arb_idx)
  );

  always_comb begin
    arb_len = '0;
    g_data  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (arb_oh[k]) arb_len = len[k*LEN_W +: LEN_W];
      if (gnt_q[k])  g_data  = op_data[k*ACC_W +: ACC_W];
    end
  end

  assign op_ready  = (state_q == ST_RUN) ? gnt_q : '0;
  assign accept    = |(op_valid & op_ready);
  // acc adds every edge, so anything but an accepted operand must be zero.
  assign acc_accin = accept ? g_data : '0;
  assign acc_cin   = 1'b0;
  assign acc_clear = ~clear_n | (state_q == ST_CLR);

  assign gnt       = gnt_q;
  assign res_valid = res_valid_q;
  assign res_id    = gid_q;
  assign res_data  = acc_accout;
  assign res_ovf   = ovf_q;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gid_d       = gid_q;
    ptr_d       = ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    res_valid_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_d   = arb_oh;
          gid_d   = arb_idx;
          cnt_d   = arb_len;
          ovf_d   = 1'b0;
          state_d = ST_CLR;
        end
      end
      ST_CLR: state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          ovf_d = ovf_q | acc_cout;
          if (cnt_q == '0) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - LEN_W'(1);
          end
        end
      end
      ST_DONE: begin
        gnt_d   = '0;
        ptr_d   = (gid_q == IDX_W'(N_REQ - 1)) ? '0 : gid_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      gid_q       <= '0;
      ptr_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gid_q       <= gid_d;
      ptr_q       <= ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      res_valid_q <= res_valid_d;
    end
  end

endmodule
